// File: rtl/master_port_arbiter_pkg.sv
// Shared sizing constants and the requester-ID type for the SDRAM master-port arbiter.
package arb_pkg;
    localparam int NUM_REQ         = 3;
    localparam int ADDR_W          = 26;
    localparam int DATA_W          = 32;
    localparam int MAX_OUTSTANDING = 8;
    localparam int ID_W            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [ID_W-1:0] req_id_t;
endpackage

// File: rtl/master_port_arbiter_if.sv
// Requester-side Avalon ports plus the shared SDRAM master port, bundled for the arbiter.
interface master_port_arbiter_if
    import arb_pkg::*;
#(
    parameter int NUM_REQ_P = NUM_REQ,
    parameter int ADDR_W_P  = ADDR_W,
    parameter int DATA_W_P  = DATA_W
) ();
    logic [NUM_REQ_P-1:0][ADDR_W_P-1:0] req_address;
    logic [NUM_REQ_P-1:0]               req_read;
    logic [NUM_REQ_P-1:0]               req_write;
    logic [NUM_REQ_P-1:0][3:0]          req_byteenable;
    logic [NUM_REQ_P-1:0][DATA_W_P-1:0] req_writedata;
    logic [NUM_REQ_P-1:0]               req_waitrequest;
    logic [NUM_REQ_P-1:0]               req_readdatavalid;
    logic [DATA_W_P-1:0]                req_readdata;

    logic [ADDR_W_P-1:0]                master_address;
    logic                               master_read;
    logic                               master_write;
    logic [3:0]                         master_byteenable;
    logic [DATA_W_P-1:0]                master_writedata;
    logic                               master_waitrequest;
    logic                               master_readdatavalid;
    logic [DATA_W_P-1:0]                master_readdata;

    // Arbiter side: consumes requests and SDRAM responses, drives the shared port.
    modport master (
        input  req_address, req_read, req_write, req_byteenable, req_writedata,
        input  master_waitrequest, master_readdatavalid, master_readdata,
        output req_waitrequest, req_readdatavalid, req_readdata,
        output master_address, master_read, master_write, master_byteenable, master_writedata
    );

    modport slave (
        output req_address, req_read, req_write, req_byteenable, req_writedata,
        output master_waitrequest, master_readdatavalid, master_readdata,
        input  req_waitrequest, req_readdatavalid, req_readdata,
        input  master_address, master_read, master_write, master_byteenable, master_writedata
    );
endinterface

// File: rtl/master_port_arbiter_id_fifo.sv
// In-order FIFO of requester IDs for reads issued but not yet returned.
module id_fifo
    import arb_pkg::*;
#(
    parameter int DEPTH = MAX_OUTSTANDING
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  req_id_t                  din_i,
    input  logic                     pop_i,
    output req_id_t                  dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    req_id_t         mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push, do_pop;

    assign full_o  = (count_q == DEPTH[AW:0]);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end
endmodule

// File: rtl/master_port_arbiter.sv
// Round-robin arbiter sharing one Avalon SDRAM master port among NUM_REQ requesters,
// with in-order read-return routing through an ID FIFO.
module master_port_arbiter
    import arb_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    master_port_arbiter_if.master bus,
    output logic                  rd_underflow
);
    logic [NUM_REQ-1:0]            active, eligible;
    req_id_t                       ptr_q, ptr_d, lock_id_q, lock_id_d, gnt_id, head_id;
    logic                          lock_q, lock_d, gnt_vld, cmd_rd, cmd_wr, accept;
    logic                          underflow_q, underflow_d;
    logic                          push, pop, fifo_full, fifo_empty, rd_pending;
    logic [$clog2(MAX_OUTSTANDING):0] fifo_count;
    int                            idx;

    always_comb begin
        active   = bus.req_read | bus.req_write;
        // A full ID FIFO blocks reads; a requester with both strobes set is a read.
        eligible = active & ~(bus.req_read & {NUM_REQ{fifo_full}});
        gnt_vld  = 1'b0;
        gnt_id   = '0;
        idx      = 0;
        if (reset) begin
            gnt_vld = 1'b0;
        end else if (lock_q) begin
            gnt_vld = eligible[lock_id_q];
            gnt_id  = lock_id_q;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(ptr_q) + k) % NUM_REQ;
                if (!gnt_vld && eligible[idx]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = req_id_t'(idx);
                end
            end
        end

        cmd_rd = gnt_vld & bus.req_read[gnt_id];
        cmd_wr = gnt_vld & ~bus.req_read[gnt_id] & bus.req_write[gnt_id];
        accept = (cmd_rd | cmd_wr) & ~bus.master_waitrequest;

        bus.master_address    = bus.req_address[gnt_id];
        bus.master_byteenable = bus.req_byteenable[gnt_id];
        bus.master_writedata  = bus.req_writedata[gnt_id];
        bus.master_read       = cmd_rd;
        bus.master_write      = cmd_wr;
        bus.req_readdata      = bus.master_readdata;

        push = accept & cmd_rd;
        pop  = bus.master_readdatavalid & rd_pending;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_waitrequest[i]   = ~(gnt_vld && (gnt_id == req_id_t'(i)) && !bus.master_waitrequest);
            bus.req_readdatavalid[i] = pop && (head_id == req_id_t'(i));
        end

        ptr_d     = ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (accept) begin
            ptr_d  = (gnt_id == req_id_t'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            lock_d = 1'b0;
        end else if (cmd_rd | cmd_wr) begin
            lock_d    = 1'b1;
            lock_id_d = gnt_id;
        end
        underflow_d = underflow_q | (bus.master_readdatavalid & fifo_empty);
    end

    assign rd_pending   = (fifo_count != '0);
    assign rd_underflow = underflow_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q       <= '0;
            lock_q      <= 1'b0;
            lock_id_q   <= '0;
            underflow_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            lock_q      <= lock_d;
            lock_id_q   <= lock_id_d;
            underflow_q <= underflow_d;
        end
    end

    id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (push),
        .din_i   (gnt_id),
        .pop_i   (pop),
        .dout_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );
endmodule

// File: tb/tb_master_port_arbiter.sv
// Directed-vector bench for master_port_arbiter: grant order, locking, read routing, FIFO limits.
module tb_master_port_arbiter;
    import arb_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rd_underflow;
    int   n_vec = 0;
    int   n_err = 0;

    master_port_arbiter_if bus();

    master_port_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .rd_underflow (rd_underflow)
    );

    always #5 clock = ~clock;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_address          = '0;
        bus.req_read             = '0;
        bus.req_write            = '0;
        bus.req_byteenable       = '1;
        bus.req_writedata        = '0;
        bus.master_waitrequest   = 1'b0;
        bus.master_readdatavalid = 1'b0;
        bus.master_readdata      = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        bus.req_read = 3'b111;
        bus.master_readdatavalid = 1'b1;
        #3;
        n_vec++; if (bus.master_read !== 1'b0) begin n_err++; $display("FAIL rst_master_read got %b want 0", bus.master_read); end
        n_vec++; if (bus.master_write !== 1'b0) begin n_err++; $display("FAIL rst_master_write got %b want 0", bus.master_write); end
        n_vec++; if (bus.req_waitrequest !== 3'b111) begin n_err++; $display("FAIL rst_waitrequest got %b want 111", bus.req_waitrequest); end
        n_vec++; if (bus.req_readdatavalid !== 3'b000) begin n_err++; $display("FAIL rst_readdatavalid got %b want 000", bus.req_readdatavalid); end
        n_vec++; if (rd_underflow !== 1'b0) begin n_err++; $display("FAIL rst_underflow got %b want 0", rd_underflow); end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        bus.req_read[1]    = 1'b1;
        bus.req_address[1] = 26'h0000100;
        #3;
        n_vec++; if (bus.master_read !== 1'b1 || bus.master_address !== 26'h0000100) begin n_err++; $display("FAIL sr_issue got rd=%b addr=%h want rd=1 addr=0000100", bus.master_read, bus.master_address); end
        n_vec++; if (bus.req_waitrequest !== 3'b101) begin n_err++; $display("FAIL sr_waitrequest got %b want 101", bus.req_waitrequest); end
        step();
        bus.req_read[1] = 1'b0;
        for (int c = 1; c < 3; c++) begin
            #3;
            n_vec++; if (bus.req_readdatavalid !== 3'b000) begin n_err++; $display("FAIL sr_early_valid cycle %0d got %b want 000", c, bus.req_readdatavalid); end
            step();
        end
        bus.master_readdatavalid = 1'b1;
        bus.master_readdata      = 32'hDEADBEEF;
        #3;
        n_vec++; if (bus.req_readdatavalid !== 3'b010) begin n_err++; $display("FAIL sr_valid got %b want 010", bus.req_readdatavalid); end
        n_vec++; if (bus.req_readdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL sr_data got %h want deadbeef", bus.req_readdata); end
        step();
        bus.master_readdatavalid = 1'b0;
        #3;
        n_vec++; if (bus.req_readdatavalid !== 3'b000 || rd_underflow !== 1'b0) begin n_err++; $display("FAIL sr_after got valid=%b uf=%b want 000/0", bus.req_readdatavalid, rd_underflow); end
        step();
    endtask

    task automatic test_round_robin();
        logic [2:0]        exp_wr;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_data;
        int                exp;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.req_write[i]     = 1'b1;
            bus.req_address[i]   = ADDR_W'(16 * (i + 1));
            bus.req_writedata[i] = DATA_W'(32'h1000 + i);
        end
        for (int k = 0; k < 6; k++) begin
            exp      = k % 3;
            exp_wr   = ~(3'b001 << exp);
            exp_addr = ADDR_W'(16 * (exp + 1));
            exp_data = DATA_W'(32'h1000 + exp);
            #3;
            n_vec++;
            if (bus.req_waitrequest !== exp_wr || bus.master_write !== 1'b1 || bus.master_address !== exp_addr || bus.master_writedata !== exp_data) begin
                n_err++;
                $display("FAIL rr_grant%0d got wr=%b addr=%h data=%h want wr=%b addr=%h data=%h", k, bus.req_waitrequest, bus.master_address, bus.master_writedata, exp_wr, exp_addr, exp_data);
            end
            step();
        end
        bus.req_write = '0;
    endtask

    task automatic test_lock();
        do_reset();
        bus.req_write[1]   = 1'b1;
        bus.req_address[1] = 26'h55;
        #3;
        n_vec++; if (bus.req_waitrequest !== 3'b101) begin n_err++; $display("FAIL lk_pre got %b want 101", bus.req_waitrequest); end
        step();
        bus.req_write[1]       = 1'b0;
        bus.req_read[0]        = 1'b1;
        bus.req_address[0]     = 26'hA0;
        bus.master_waitrequest = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                bus.req_write[2]   = 1'b1;
                bus.req_address[2] = 26'hC0;
            end
            #3;
            n_vec++;
            if (bus.master_address !== 26'hA0 || bus.master_read !== 1'b1 || bus.master_write !== 1'b0 || bus.req_waitrequest !== 3'b111) begin
                n_err++;
                $display("FAIL lk_hold%0d got addr=%h rd=%b wr=%b wait=%b want A0/1/0/111", c, bus.master_address, bus.master_read, bus.master_write, bus.req_waitrequest);
            end
            step();
        end
        bus.master_waitrequest = 1'b0;
        #3;
        n_vec++; if (bus.req_waitrequest !== 3'b110 || bus.master_address !== 26'hA0) begin n_err++; $display("FAIL lk_accept got wait=%b addr=%h want 110/A0", bus.req_waitrequest, bus.master_address); end
        step();
        bus.req_read[0] = 1'b0;
        #3;
        n_vec++; if (bus.master_write !== 1'b1 || bus.master_address !== 26'hC0 || bus.req_waitrequest !== 3'b011) begin n_err++; $display("FAIL lk_next got wr=%b addr=%h wait=%b want 1/C0/011", bus.master_write, bus.master_address, bus.req_waitrequest); end
        step();
        bus.req_write[2] = 1'b0;
    endtask

    task automatic test_fifo_full();
        do_reset();
        bus.req_read[0] = 1'b1;
        for (int k = 0; k < MAX_OUTSTANDING; k++) begin
            bus.req_address[0] = ADDR_W'(32'h200 + k);
            #3;
            n_vec++; if (bus.req_waitrequest !== 3'b110 || bus.master_read !== 1'b1) begin n_err++; $display("FAIL ff_fill%0d got wait=%b rd=%b want 110/1", k, bus.req_waitrequest, bus.master_read); end
            step();
        end
        bus.req_address[0] = 26'h208;
        bus.req_write[1]   = 1'b1;
        bus.req_address[1] = 26'h300;
        #3;
        n_vec++; if (bus.master_read !== 1'b0 || bus.master_write !== 1'b1 || bus.master_address !== 26'h300 || bus.req_waitrequest !== 3'b101) begin n_err++; $display("FAIL ff_write got rd=%b wr=%b addr=%h wait=%b want 0/1/300/101", bus.master_read, bus.master_write, bus.master_address, bus.req_waitrequest); end
        step();
        bus.req_write[1]         = 1'b0;
        bus.master_readdatavalid = 1'b1;
        bus.master_readdata      = 32'h00001234;
        #3;
        n_vec++; if (bus.req_waitrequest !== 3'b111 || bus.master_read !== 1'b0) begin n_err++; $display("FAIL ff_samepop got wait=%b rd=%b want 111/0", bus.req_waitrequest, bus.master_read); end
        n_vec++; if (bus.req_readdatavalid !== 3'b001 || bus.req_readdata !== 32'h00001234) begin n_err++; $display("FAIL ff_return got valid=%b data=%h want 001/00001234", bus.req_readdatavalid, bus.req_readdata); end
        step();
        bus.master_readdatavalid = 1'b0;
        #3;
        n_vec++; if (bus.req_waitrequest !== 3'b110 || bus.master_read !== 1'b1 || bus.master_address !== 26'h208) begin n_err++; $display("FAIL ff_unblock got wait=%b rd=%b addr=%h want 110/1/208", bus.req_waitrequest, bus.master_read, bus.master_address); end
        step();
        bus.req_read[0] = 1'b0;
    endtask

    task automatic test_in_order();
        do_reset();
        bus.req_read[0]    = 1'b1;
        bus.req_address[0] = 26'h400;
        #3;
        n_vec++; if (bus.req_waitrequest !== 3'b110) begin n_err++; $display("FAIL io_rd0 got %b want 110", bus.req_waitrequest); end
        step();
        bus.req_read[0]    = 1'b0;
        bus.req_read[2]    = 1'b1;
        bus.req_address[2] = 26'h402;
        #3;
        n_vec++; if (bus.req_waitrequest !== 3'b011 || bus.master_address !== 26'h402) begin n_err++; $display("FAIL io_rd2 got wait=%b addr=%h want 011/402", bus.req_waitrequest, bus.master_address); end
        step();
        bus.req_read[2]          = 1'b0;
        bus.req_read[1]          = 1'b1;
        bus.req_address[1]       = 26'h401;
        bus.master_readdatavalid = 1'b1;
        bus.master_readdata      = 32'hAAAA0000;
        #3;
        n_vec++; if (bus.req_waitrequest !== 3'b101) begin n_err++; $display("FAIL io_rd1 got %b want 101", bus.req_waitrequest); end
        n_vec++; if (bus.req_readdatavalid !== 3'b001 || bus.req_readdata !== 32'hAAAA0000) begin n_err++; $display("FAIL io_retA got valid=%b data=%h want 001/aaaa0000", bus.req_readdatavalid, bus.req_readdata); end
        step();
        bus.req_read[1]     = 1'b0;
        bus.master_readdata = 32'hBBBB1111;
        #3;
        n_vec++; if (bus.req_readdatavalid !== 3'b100 || bus.req_readdata !== 32'hBBBB1111) begin n_err++; $display("FAIL io_retB got valid=%b data=%h want 100/bbbb1111", bus.req_readdatavalid, bus.req_readdata); end
        step();
        bus.master_readdata = 32'hCCCC2222;
        #3;
        n_vec++; if (bus.req_readdatavalid !== 3'b010 || bus.req_readdata !== 32'hCCCC2222) begin n_err++; $display("FAIL io_retC got valid=%b data=%h want 010/cccc2222", bus.req_readdatavalid, bus.req_readdata); end
        step();
        bus.master_readdatavalid = 1'b0;
        #3;
        n_vec++; if (bus.req_readdatavalid !== 3'b000 || rd_underflow !== 1'b0) begin n_err++; $display("FAIL io_drained got valid=%b uf=%b want 000/0", bus.req_readdatavalid, rd_underflow); end
        step();
    endtask

    task automatic test_underflow();
        do_reset();
        bus.master_readdatavalid = 1'b1;
        #3;
        n_vec++; if (bus.req_readdatavalid !== 3'b000) begin n_err++; $display("FAIL uf_stray_valid got %b want 000", bus.req_readdatavalid); end
        step();
        bus.master_readdatavalid = 1'b0;
        #3;
        n_vec++; if (rd_underflow !== 1'b1) begin n_err++; $display("FAIL uf_set got %b want 1", rd_underflow); end
        step();
        step();
        #3;
        n_vec++; if (rd_underflow !== 1'b1) begin n_err++; $display("FAIL uf_sticky got %b want 1", rd_underflow); end
        step();
        do_reset();
        #3;
        n_vec++; if (rd_underflow !== 1'b0) begin n_err++; $display("FAIL uf_cleared got %b want 0", rd_underflow); end
        bus.req_read[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.req_address[0] = ADDR_W'(32'h500 + k);
            step();
        end
        bus.req_read[0] = 1'b0;
        do_reset();
        #3;
        n_vec++; if (rd_underflow !== 1'b0) begin n_err++; $display("FAIL uf_midreset got %b want 0", rd_underflow); end
        step();
        bus.master_readdatavalid = 1'b1;
        #3;
        n_vec++; if (bus.req_readdatavalid !== 3'b000) begin n_err++; $display("FAIL uf_dropped_valid got %b want 000", bus.req_readdatavalid); end
        step();
        bus.master_readdatavalid = 1'b0;
        #3;
        n_vec++; if (rd_underflow !== 1'b1) begin n_err++; $display("FAIL uf_after_reset got %b want 1", rd_underflow); end
        step();
    endtask

    initial begin
        idle_inputs();
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_fifo_full();
        test_in_order();
        test_underflow();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
